risc16_execute_unit: RTL and testbench
======================================

Name: risc16_execute_unit

Overview:
- Execute-stage datapath of the 8-bit RISC core: operand-select muxes, 8-bit ALU with branch compare, branch-qualify AND, write-back mux and PC-increment mux.
- Sits between register file/decoder/control unit and data memory/program counter.
- Only state is a 4-bit status-flag register (Z, C, N, V). All other paths are combinational.

Parameters:
- DATA_W, 8, datapath width (all data ports, immediate, pc_increment).

Ports:
- clk  in  1  rising-edge clock for the flag register
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- opcode  in  4  operation select from the decoder
- read_data1  in  8  register-file port 1
- read_data2  in  8  register-file port 2
- immediate  in  8  decoded immediate / branch offset
- ALU_src  in  1  1: operand B = immediate; 0: operand B = read_data2
- load  in  1  1: operand A = immediate and write_data = mem_read_data
- branch  in  1  control-unit branch enable
- mem_read_data  in  8  data-memory read value
- alu_result  out  8  ALU result; also drives the data-memory address
- compare  out  1  branch condition true
- branch_taken  out  1  branch AND compare
- pc_increment  out  8  immediate if branch_taken, else 8'd1
- write_data  out  8  register write-back value
- flags  out  4  {Z,C,N,V} registered

Behaviour:
- Operand select: A = load ? immediate : read_data1. B = ALU_src ? immediate : read_data2. Purely combinational.
- Opcode map (A, B 8-bit unsigned; all results wrap mod 256):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A
  - 6 SHL: A<<B[2:0]
  - 7 SHR logical: A>>B[2:0]
  - 8 ADC: A+B+C_q
  - 9 ADDR: A+B (load/store address)
  - A BEQ
  - B BNE
  - C BLT signed
  - D BLTU unsigned
  - E PASS: result = B
  - F NOP: result = 0
- Branch opcodes A–D: alu_result = A-B (wrapped). compare = condition (A==B, A!=B, $signed(A)<$signed(B), A<B respectively).
- All non-branch opcodes drive compare = 0.
- branch_taken = branch & compare. pc_increment = branch_taken ? immediate : 8'd1.
- write_data = load ? mem_read_data : alu_result.
- All outputs except flags settle combinationally in the same cycle (zero latency).
- Flag register, updated at posedge clk only for opcodes 0–8; held for all others:
  - Z = (result==0)
  - N = result[7]
  - C: carry-out for ADD/ADC; borrow (A<B unsigned) for SUB; last bit shifted out for SHL/SHR (0 when shift amount is 0); 0 for logic ops 2–5.
  - V: signed overflow for ADD/ADC/SUB; 0 otherwise.
- ADC uses the registered C_q, not a combinational carry.
- Reset (rst=0, asynchronous) clears flags to 4'b0000 immediately, independent of clk. Combinational outputs are unaffected by reset.
- First posedge after reset release updates flags normally.
- Boundaries:
  - ADD 0xFF+0x01 → 0x00, Z=1, C=1.
  - SUB 0x00-0x01 → 0xFF, C=1, N=1.
  - Signed 0x7F+0x01 → V=1.
  - BLT 0x80 vs 0x01 → compare=1. BLTU on the same operands → 0.
  - branch=1 with compare=0 → pc_increment=1.
  - load=1 with ALU_src=1 → both operands = immediate.

Decomposition:
- Shared package risc16_pkg:
  - opcode localparams OP_ADD…OP_NOP (4'h0–4'hF)
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0
  - DATA_W
- One sub-module, risc16_alu_core: combinational A, B, opcode, carry_in → result, compare, next_flags.
- The top holds the muxes, the AND, and the flag register.

Test Plan:
- Reset: rst=0 mid-cycle after ADD set flags → flags=0000 immediately without clock edge. Release, ADD 0x00+0x00 → next posedge flags Z=1.
- Arithmetic: ADD 0xFF+0x01 → alu_result=0x00, flags after edge {1,1,0,0}. Then ADC 0x01+0x01 → 0x03. SUB 0x05-0x07 → 0xFE, C=1, N=1.
- Operand muxes: read_data1=0x10, read_data2=0x20, immediate=0x05, ADD:
  - ALU_src=0 → 0x30
  - ALU_src=1 → 0x15
  - load=1, ALU_src=1 → 0x0A, with write_data=mem_read_data (0xAB).
- Branch: BEQ 0x33 vs 0x33, branch=1, immediate=0xFC → compare=1, pc_increment=0xFC. Same with branch=0 → pc_increment=0x01. BNE equal operands → pc_increment=0x01.
- Signed compare: BLT 0x80 vs 0x01 → compare=1. BLTU same operands → compare=0. Flags unchanged across all branch ops.
- Shifts/logic: SHL 0x81 by 1 → 0x02, C=1. SHR 0x01 by 1 → 0x00, Z=1, C=1. NOT 0x0F → 0xF0, N=1, C=0.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared definitions for the 8-bit RISC execute stage: datapath width,
// opcode encodings and status-flag bit positions.
package risc16_pkg;

   localparam int DATA_W = 8;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_ADC  = 4'h8;
   localparam logic [3:0] OP_ADDR = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_BNE  = 4'hB;
   localparam logic [3:0] OP_BLT  = 4'hC;
   localparam logic [3:0] OP_BLTU = 4'hD;
   localparam logic [3:0] OP_PASS = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   // Only the arithmetic, logic and shift group (ADD..ADC) touches the flags.
   function automatic logic flag_update(input logic [3:0] op);
      return (op <= OP_ADC);
   endfunction

endpackage

// File: rtl/risc16_execute_unit_if.sv
// Execute-stage bus: operands and controls from decode/control, results
// toward memory, program counter and register write-back.
interface risc16_execute_unit_if;
   import risc16_pkg::*;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic [DATA_W-1:0] immediate;
   logic              ALU_src;
   logic              load;
   logic              branch;
   logic [DATA_W-1:0] mem_read_data;

   logic [DATA_W-1:0] alu_result;
   logic              compare;
   logic              branch_taken;
   logic [DATA_W-1:0] pc_increment;
   logic [DATA_W-1:0] write_data;
   logic [3:0]        flags;

   modport master (
      output opcode, read_data1, read_data2, immediate, ALU_src, load, branch, mem_read_data,
      input  alu_result, compare, branch_taken, pc_increment, write_data, flags
   );

   modport slave (
      input  opcode, read_data1, read_data2, immediate, ALU_src, load, branch, mem_read_data,
      output alu_result, compare, branch_taken, pc_increment, write_data, flags
   );

endinterface

// File: rtl/risc16_alu_core.sv
// Combinational ALU: result, branch condition and the flag values the
// current operation would produce.
module risc16_alu_core
   import risc16_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        opcode,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              compare,
   output logic [3:0]        next_flags
);

   logic [DATA_W:0] sum_wide;
   logic [DATA_W:0] diff_wide;
   logic [DATA_W:0] shl_wide;
   logic [DATA_W:0] shr_wide;
   logic [2:0]      shamt;
   logic            cin_eff;
   logic            carry;
   logic            overflow;

   assign shamt     = b[2:0];
   assign cin_eff   = (opcode == OP_ADC) ? carry_in : 1'b0;
   assign sum_wide  = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin_eff};
   assign diff_wide = {1'b0, a} - {1'b0, b};
   // The extra bit of each shift catches the last bit pushed out; it stays 0 for a zero shift.
   assign shl_wide  = {1'b0, a} << shamt;
   assign shr_wide  = {a, 1'b0} >> shamt;

   always_comb begin
      result   = '0;
      compare  = 1'b0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC: begin
            result   = sum_wide[DATA_W-1:0];
            carry    = sum_wide[DATA_W];
            overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OP_SUB: begin
            result   = diff_wide[DATA_W-1:0];
            carry    = diff_wide[DATA_W];
            overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SHL: begin
            result = shl_wide[DATA_W-1:0];
            carry  = shl_wide[DATA_W];
         end
         OP_SHR: begin
            result = shr_wide[DATA_W:1];
            carry  = shr_wide[0];
         end
         OP_ADDR: result = sum_wide[DATA_W-1:0];
         OP_BEQ: begin
            result  = diff_wide[DATA_W-1:0];
            compare = (a == b);
         end
         OP_BNE: begin
            result  = diff_wide[DATA_W-1:0];
            compare = (a != b);
         end
         OP_BLT: begin
            result  = diff_wide[DATA_W-1:0];
            compare = ($signed(a) < $signed(b));
         end
         OP_BLTU: begin
            result  = diff_wide[DATA_W-1:0];
            compare = (a < b);
         end
         OP_PASS: result = b;
         default: result = '0;
      endcase
   end

   always_comb begin
      next_flags         = '0;
      next_flags[FLAG_Z] = (result == '0);
      next_flags[FLAG_C] = carry;
      next_flags[FLAG_N] = result[DATA_W-1];
      next_flags[FLAG_V] = overflow;
   end

endmodule

// File: rtl/risc16_execute_unit.sv
// Execute stage: operand muxes, ALU, branch qualification, write-back and
// PC-increment muxes, plus the registered status flags.
module risc16_execute_unit
   import risc16_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   risc16_execute_unit_if.slave  bus
);

   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [DATA_W-1:0] alu_result;
   logic              compare;
   logic              branch_taken;
   logic [3:0]        flags_reg;
   logic [3:0]        flags_next;
   logic [3:0]        alu_flags;

   assign operand_a = bus.load    ? bus.immediate : bus.read_data1;
   assign operand_b = bus.ALU_src ? bus.immediate : bus.read_data2;

   risc16_alu_core u_alu_core (
      .a          (operand_a),
      .b          (operand_b),
      .opcode     (bus.opcode),
      .carry_in   (flags_reg[FLAG_C]),
      .result     (alu_result),
      .compare    (compare),
      .next_flags (alu_flags)
   );

   assign branch_taken     = bus.branch & compare;
   assign bus.alu_result   = alu_result;
   assign bus.compare      = compare;
   assign bus.branch_taken = branch_taken;
   assign bus.pc_increment = branch_taken ? bus.immediate : {{(DATA_W-1){1'b0}}, 1'b1};
   assign bus.write_data   = bus.load ? bus.mem_read_data : alu_result;
   assign bus.flags        = flags_reg;

   assign flags_next = flag_update(bus.opcode) ? alu_flags : flags_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_reg <= 4'b0000;
      end else begin
         flags_reg <= flags_next;
      end
   end

endmodule

// File: tb/tb_risc16_execute_unit.sv
// Directed bench for the execute stage: one task per feature, inline checks.
module tb_risc16_execute_unit;
   import risc16_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   risc16_execute_unit_if bus ();

   risc16_execute_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] op, input logic [7:0] rd1, input logic [7:0] rd2,
                        input logic [7:0] imm, input logic alu_src, input logic ld,
                        input logic br, input logic [7:0] mem);
      bus.opcode        = op;
      bus.read_data1    = rd1;
      bus.read_data2    = rd2;
      bus.immediate     = imm;
      bus.ALU_src       = alu_src;
      bus.load          = ld;
      bus.branch        = br;
      bus.mem_read_data = mem;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(OP_NOP, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++;
      if (bus.flags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_initial flags=%b expected=%b", bus.flags, 4'b0000);
      end
      rst = 1'b1;
      drive(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++;
      if (bus.flags !== 4'b1100) begin
         errors++;
         $display("FAIL reset_preset flags=%b expected=%b", bus.flags, 4'b1100);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.flags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async flags=%b expected=%b", bus.flags, 4'b0000);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(OP_ADD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++;
      if (bus.flags !== 4'b1000) begin
         errors++;
         $display("FAIL reset_release flags=%b expected=%b", bus.flags, 4'b1000);
      end
      $display("test_reset done");
   endtask

   task automatic test_arith();
      drive(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'h00) begin
         errors++;
         $display("FAIL add_wrap result=%h expected=%h", bus.alu_result, 8'h00);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b1100) begin
         errors++;
         $display("FAIL add_wrap_flags flags=%b expected=%b", bus.flags, 4'b1100);
      end
      drive(OP_ADC, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'h03) begin
         errors++;
         $display("FAIL adc result=%h expected=%h", bus.alu_result, 8'h03);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0000) begin
         errors++;
         $display("FAIL adc_flags flags=%b expected=%b", bus.flags, 4'b0000);
      end
      drive(OP_SUB, 8'h05, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'hFE) begin
         errors++;
         $display("FAIL sub result=%h expected=%h", bus.alu_result, 8'hFE);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0110) begin
         errors++;
         $display("FAIL sub_flags flags=%b expected=%b", bus.flags, 4'b0110);
      end
      $display("test_arith done");
   endtask

   task automatic test_operand_mux();
      drive(OP_ADD, 8'h10, 8'h20, 8'h05, 1'b0, 1'b0, 1'b0, 8'hAB);
      checks++;
      if (bus.alu_result !== 8'h30 || bus.write_data !== 8'h30) begin
         errors++;
         $display("FAIL mux_reg result=%h wd=%h expected=%h", bus.alu_result, bus.write_data, 8'h30);
      end
      drive(OP_ADD, 8'h10, 8'h20, 8'h05, 1'b1, 1'b0, 1'b0, 8'hAB);
      checks++;
      if (bus.alu_result !== 8'h15) begin
         errors++;
         $display("FAIL mux_imm result=%h expected=%h", bus.alu_result, 8'h15);
      end
      drive(OP_ADD, 8'h10, 8'h20, 8'h05, 1'b1, 1'b1, 1'b0, 8'hAB);
      checks++;
      if (bus.alu_result !== 8'h0A) begin
         errors++;
         $display("FAIL mux_load result=%h expected=%h", bus.alu_result, 8'h0A);
      end
      checks++;
      if (bus.write_data !== 8'hAB) begin
         errors++;
         $display("FAIL mux_load_wd write_data=%h expected=%h", bus.write_data, 8'hAB);
      end
      $display("test_operand_mux done");
   endtask

   task automatic test_branch();
      // 0x7F+0x01 sets N and V; every branch below must leave 0011 intact.
      drive(OP_ADD, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++;
      if (bus.flags !== 4'b0011) begin
         errors++;
         $display("FAIL add_overflow flags=%b expected=%b", bus.flags, 4'b0011);
      end
      drive(OP_BEQ, 8'h33, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.compare !== 1'b1 || bus.branch_taken !== 1'b1 || bus.pc_increment !== 8'hFC) begin
         errors++;
         $display("FAIL beq_taken cmp=%b taken=%b pc=%h expected 1 1 fc", bus.compare, bus.branch_taken, bus.pc_increment);
      end
      checks++;
      if (bus.alu_result !== 8'h00) begin
         errors++;
         $display("FAIL beq_result result=%h expected=%h", bus.alu_result, 8'h00);
      end
      tick();
      drive(OP_BEQ, 8'h33, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.branch_taken !== 1'b0 || bus.pc_increment !== 8'h01) begin
         errors++;
         $display("FAIL beq_nobranch taken=%b pc=%h expected 0 01", bus.branch_taken, bus.pc_increment);
      end
      tick();
      drive(OP_BNE, 8'h33, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.compare !== 1'b0 || bus.pc_increment !== 8'h01) begin
         errors++;
         $display("FAIL bne_equal cmp=%b pc=%h expected 0 01", bus.compare, bus.pc_increment);
      end
      tick();
      drive(OP_BLT, 8'h80, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.compare !== 1'b1 || bus.pc_increment !== 8'h10) begin
         errors++;
         $display("FAIL blt_signed cmp=%b pc=%h expected 1 10", bus.compare, bus.pc_increment);
      end
      checks++;
      if (bus.alu_result !== 8'h7F) begin
         errors++;
         $display("FAIL blt_result result=%h expected=%h", bus.alu_result, 8'h7F);
      end
      tick();
      drive(OP_BLTU, 8'h80, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.compare !== 1'b0 || bus.pc_increment !== 8'h01) begin
         errors++;
         $display("FAIL bltu_unsigned cmp=%b pc=%h expected 0 01", bus.compare, bus.pc_increment);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0011) begin
         errors++;
         $display("FAIL branch_flags_held flags=%b expected=%b", bus.flags, 4'b0011);
      end
      $display("test_branch done");
   endtask

   task automatic test_shift_logic();
      drive(OP_SHL, 8'h81, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'h02 || bus.compare !== 1'b0) begin
         errors++;
         $display("FAIL shl result=%h cmp=%b expected 02 0", bus.alu_result, bus.compare);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0100) begin
         errors++;
         $display("FAIL shl_flags flags=%b expected=%b", bus.flags, 4'b0100);
      end
      drive(OP_SHR, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'h00) begin
         errors++;
         $display("FAIL shr result=%h expected=%h", bus.alu_result, 8'h00);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b1100) begin
         errors++;
         $display("FAIL shr_flags flags=%b expected=%b", bus.flags, 4'b1100);
      end
      drive(OP_NOT, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'hF0) begin
         errors++;
         $display("FAIL not result=%h expected=%h", bus.alu_result, 8'hF0);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0010) begin
         errors++;
         $display("FAIL not_flags flags=%b expected=%b", bus.flags, 4'b0010);
      end
      drive(OP_NOP, 8'h55, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.alu_result !== 8'h00) begin
         errors++;
         $display("FAIL nop result=%h expected=%h", bus.alu_result, 8'h00);
      end
      tick();
      checks++;
      if (bus.flags !== 4'b0010) begin
         errors++;
         $display("FAIL nop_flags_held flags=%b expected=%b", bus.flags, 4'b0010);
      end
      $display("test_shift_logic done");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_arith();
      test_operand_mux();
      test_branch();
      test_shift_logic();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
